imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder for the core's external fetch port. Serves exIns_ren/exIns_addr
//   requests with exIns_valid/exIns_in responses after a fixed, parameterised latency. Fully
//   pipelined. A side loader port writes program words before or during run.
//   Sits at top level between the testbench/loader and core, port-to-port with the core fetch pins.
// PARAMETERS
//   DEPTH     1024           number of 32-bit words; power of two, >= 2
//   LATENCY   2              request-to-response cycles; legal 1..4
//   BASE_ADDR 32'h0000_0000  byte address of word 0; DEPTH*4-aligned
// PORTS
//   clk         in   1   clock, all logic on rising edge
//   rst         in   1   reset; one clock; reset is synchronous and active-high
//   exIns_ren   in   1   fetch request strobe from core; one request per high cycle
//   exIns_addr  in   32  fetch byte address, sampled when exIns_ren=1
//   exIns_valid out  1   one-cycle pulse per accepted request
//   exIns_in    out  32  instruction word, qualified by exIns_valid
//   load_en     in   1   loader write strobe
//   load_addr   in   32  loader byte address (word-aligned, in range, else dropped)
//   load_data   in   32  loader write data
//   err_clr     in   1   clears err and err_addr
//   err         out  1   sticky: a fetch was misaligned or out of range
//   err_addr    out  32  address of first faulting fetch since reset/err_clr
//   req_cnt     out  16  accepted fetch count, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (rst=1 at edge): exIns_valid=0, exIns_in=0, err=0, err_addr=0, req_cnt=0,
//   pipeline valid bits cleared. Memory contents NOT cleared.
// - In-flight requests at reset are discarded; no exIns_valid for them after reset.
// - Requests issued in a rst=1 cycle are ignored.
// - Acceptance: every cycle with exIns_ren=1 and rst=0 accepts a request; no backpressure.
// - Response timing: request at edge N gives exIns_valid=1 with data in the cycle after edge
//   N+LATENCY-1, i.e. LATENCY cycles after request. Responses are in order, exactly one per request.
// - Back-to-back requests give back-to-back valid pulses.
// - Data path:
//   - Registered synchronous read at stage 1.
//   - LATENCY-1 further register stages carry {valid, data}.
//   - exIns_in holds its last value while exIns_valid=0.
// - Address decode: idx = (exIns_addr - BASE_ADDR) >> 2, 32-bit modular subtract.
//   - In range iff exIns_addr[1:0]==0 and idx < DEPTH.
// - Fault (misaligned or out of range):
//   - Response still issued on time, with data 32'h0000_0013 (NOP).
//   - err set on the acceptance edge.
//   - err_addr loaded only if err was 0 before that edge (first fault kept).
//   - err_clr and a new fault in the same cycle: err=1, err_addr = new fault address.
// - Loader:
//   - load_en with aligned, in-range load_addr writes load_data at the edge.
//   - Illegal loader address: write silently dropped, err not affected.
// - Same-cycle fetch and load to the same word: fetch returns the OLD word (read-before-write).
//   The next fetch returns the new word.
// - req_cnt increments once per accepted request, faulting ones included, and holds at 16'hFFFF.
// TESTING
// 1. LATENCY=2: load words 0..3 = 32'hA0..A3; ren at addr 0,4,8,12 on 4 consecutive cycles.
//    Required: valid high 4 consecutive cycles starting 2 cycles later, data A0,A1,A2,A3,
//    req_cnt=4.
// 2. Fetch addr 32'h0000_0002, then addr DEPTH*4.
//    Required: two NOP (32'h13) responses, err=1, err_addr=32'h2. Then err_clr -> err=0, err_addr=0.
// 3. Same cycle: load word 5 = 32'hDEAD_BEEF while fetching addr 20 (old 32'h1111_1111).
//    Required: response 32'h1111_1111. Next fetch of addr 20 returns 32'hDEAD_BEEF.
// 4. Issue 3 requests, assert rst for 1 cycle on the next edge.
//    Required: no exIns_valid for any of them; all outputs at reset values; memory word 0 intact.
// 5. Sweep LATENCY=1 and LATENCY=4 with random ren pattern vs. reference queue model.
//    Required: 1:1 in-order responses at exact latency.
// 6. Issue 70000 requests. Required: req_cnt saturates at 16'hFFFF and stays.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder for the core's external fetch port.
// Fetches are answered after a fixed LATENCY with the stored word, or with a
// NOP when the fetch address is misaligned or outside the memory window.
// A side loader port writes program words at any time. A sticky error flag
// records the first faulting fetch address, and a saturating counter counts
// accepted fetches.
module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exIns_ren,
    input  logic [31:0] exIns_addr,
    output logic        exIns_valid,
    output logic [31:0] exIns_in,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        err_clr,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [15:0] req_cnt
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // An offset from BASE_ADDR is legal when word-aligned and inside the window.
    function automatic logic addr_ok(input logic [31:0] off);
        return (off[1:0] == 2'b00) && ((off >> 2) < DEPTH_W);
    endfunction

    logic [31:0] r_mem [DEPTH];

    logic        r_pv [LATENCY];
    logic [31:0] r_pd [LATENCY];

    logic        r_err;
    logic [31:0] r_err_addr;
    logic [15:0] r_req_cnt;

    logic [31:0] w_fetch_off;
    logic        w_fetch_ok;
    logic [AW-1:0] w_fetch_idx;
    logic        w_fetch_fault;
    logic        w_accept;

    logic [31:0] w_load_off;
    logic        w_load_ok;
    logic [AW-1:0] w_load_idx;

    // Modular subtract so a BASE_ADDR above the fetch address wraps far out of range.
    assign w_fetch_off   = exIns_addr - BASE_ADDR;
    assign w_fetch_ok    = addr_ok(w_fetch_off);
    assign w_fetch_idx   = w_fetch_off[AW+1:2];
    assign w_accept      = exIns_ren & ~rst;
    assign w_fetch_fault = w_accept & ~w_fetch_ok;

    assign w_load_off = load_addr - BASE_ADDR;
    assign w_load_ok  = load_en & addr_ok(w_load_off);
    assign w_load_idx = w_load_off[AW+1:2];

    // Loader writes; memory is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    // Read stage plus LATENCY-1 carry stages of {valid, data}. The read uses the
    // pre-edge memory contents, so a same-cycle load is seen only by later fetches.
    // Data registers load only behind a valid bit so the output holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'h0000_0000;
            end
        end else begin
            r_pv[0] <= exIns_ren;
            if (exIns_ren) begin
                r_pd[0] <= w_fetch_ok ? r_mem[w_fetch_idx] : NOP;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    // Sticky fault flag; the first address is kept unless a clear coincides with a new fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0000_0000;
        end else if (w_fetch_fault) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
                r_err_addr <= exIns_addr;
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0000_0000;
        end
    end

    // Saturating count of accepted fetches, faulting ones included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_cnt <= 16'h0000;
        end else if (w_accept && (r_req_cnt != 16'hFFFF)) begin
            r_req_cnt <= r_req_cnt + 16'd1;
        end
    end

    assign exIns_valid = r_pv[LATENCY-1];
    assign exIns_in    = r_pd[LATENCY-1];
    assign err         = r_err;
    assign err_addr    = r_err_addr;
    assign req_cnt     = r_req_cnt;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (LATENCY 1, 2, 4) share
// one randomized stimulus stream. A reference model computes each response
// when the fetch is issued and queues it; per-instance monitors pop and
// compare data and exact latency whenever a valid pulse appears.
module tb_imem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ren, ld, clr;
    logic [31:0] addr, la, ldat;

    logic        v  [3];
    logic [31:0] d  [3];
    logic        e  [3];
    logic [31:0] ea [3];
    logic [15:0] rc [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(
            .DEPTH(DEPTH),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .BASE_ADDR(BASE)
        ) u_dut (
            .clk(clk), .rst(rst),
            .exIns_ren(ren), .exIns_addr(addr),
            .exIns_valid(v[g]), .exIns_in(d[g]),
            .load_en(ld), .load_addr(la), .load_data(ldat),
            .err_clr(clr), .err(e[g]), .err_addr(ea[g]), .req_cnt(rc[g])
        );
    end

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q [3][$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mmem [DEPTH];
    logic        m_err;
    logic [31:0] m_ea;
    int          m_cnt;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic bit m_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return ((off % 32'd4) == 32'd0) && ((off / 32'd4) < 32'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 32'd4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        else if (r == 7) return BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        else if (r == 8) return BASE + 32'(DEPTH) * 32'd4 + 32'($urandom_range(0, 255)) * 32'd4;
        else             return $urandom;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: match every valid pulse to the oldest expected response; flag overdue ones.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            while (q[k].size() > 0 && (q[k][0].c + lat(k) - 1) < cyc) begin
                exp_t x;
                x = q[k].pop_front();
                chk($sformatf("missing_resp_L%0d", lat(k)), 32'd0, 32'd1);
            end
            if (v[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("spurious_valid_L%0d", lat(k)), 32'd1, 32'd0);
                end else begin
                    exp_t x;
                    x = q[k].pop_front();
                    chk($sformatf("data_L%0d", lat(k)), d[k], x.d);
                    chk($sformatf("latency_L%0d", lat(k)), 32'(cyc - x.c), 32'(lat(k) - 1));
                end
            end
        end
    end

    // One clock of stimulus: drive inputs, advance the model, then check the status outputs.
    task automatic step(input logic r, input logic [31:0] a, input logic l, input logic [31:0] lad,
                        input logic [31:0] ldd, input logic c, input logic rs);
        bit fault;
        logic [31:0] dd;
        ren = r; addr = a; ld = l; la = lad; ldat = ldd; clr = c; rst = rs;
        if (!rs) begin
            if (r) begin
                dd = m_ok(a) ? mmem[m_idx(a)] : NOP;
                for (int k = 0; k < 3; k++) q[k].push_back('{d: dd, c: cyc + 1});
            end
            fault = r && !m_ok(a);
            if (fault) begin
                if (!m_err || c) m_ea = a;
                m_err = 1'b1;
            end else if (c) begin
                m_err = 1'b0;
                m_ea  = 32'd0;
            end
            if (r && m_cnt < 65535) m_cnt++;
        end else begin
            m_err = 1'b0;
            m_ea  = 32'd0;
            m_cnt = 0;
        end
        if (l && m_ok(lad)) mmem[m_idx(lad)] = ldd;
        @(posedge clk);
        #1;
        if (rs) begin
            for (int k = 0; k < 3; k++) q[k].delete();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("err_L%0d", lat(k)), {31'd0, e[k]}, {31'd0, m_err});
            chk($sformatf("err_addr_L%0d", lat(k)), ea[k], m_ea);
            chk($sformatf("req_cnt_L%0d", lat(k)), {16'd0, rc[k]}, 32'(m_cnt));
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] dat);
        step(1'b0, 32'd0, 1'b1, a, dat, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; addr = 32'd0; ld = 1'b0; la = 32'd0; ldat = 32'd0; clr = 1'b0;
        m_err = 1'b0; m_ea = 32'd0; m_cnt = 0;
        @(posedge clk);
        #1;
        step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid_L%0d", lat(k)), {31'd0, v[k]}, 32'd0);
            chk($sformatf("rst_data_L%0d", lat(k)), d[k], 32'd0);
        end

        // Preload every word, then words 0..3 with known values.
        for (int i = 0; i < DEPTH; i++) load(BASE + 32'(i) * 32'd4, $urandom);
        for (int i = 0; i < 4; i++) load(BASE + 32'(i) * 32'd4, 32'hA0 + 32'(i));

        // Back-to-back fetches of words 0..3.
        for (int i = 0; i < 4; i++) fetch(BASE + 32'(i) * 32'd4);
        chk("req_cnt_after_4", {16'd0, rc[1]}, 32'd4);
        idle(5);

        // Misaligned and out-of-range fetches, then clear.
        fetch(BASE + 32'h2);
        fetch(BASE + 32'(DEPTH) * 32'd4);
        idle(5);
        chk("err_set", {31'd0, e[1]}, 32'd1);
        chk("err_addr_first", ea[1], 32'h2);
        step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("err_cleared", {31'd0, e[1]}, 32'd0);
        chk("err_addr_cleared", ea[1], 32'd0);

        // Clear coinciding with a new fault keeps the new address.
        fetch(BASE + 32'h5);
        step(1'b1, BASE + 32'h7, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("err_addr_clr_fault", ea[1], BASE + 32'h7);
        step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Read-before-write on a same-cycle fetch and load.
        load(BASE + 32'd20, 32'h1111_1111);
        step(1'b1, BASE + 32'd20, 1'b1, BASE + 32'd20, 32'hDEAD_BEEF, 1'b0, 1'b0);
        fetch(BASE + 32'd20);
        idle(5);

        // Illegal loader addresses are dropped without touching err.
        load(BASE + 32'h6, 32'hBAD0_0001);
        load(BASE + 32'(DEPTH) * 32'd4, 32'hBAD0_0002);
        fetch(BASE + 32'h4);
        idle(5);

        // In-flight requests discarded by reset.
        for (int i = 0; i < 3; i++) fetch(BASE + 32'(i) * 32'd4);
        step(1'b1, BASE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst2_valid_L%0d", lat(k)), {31'd0, v[k]}, 32'd0);
            chk($sformatf("rst2_data_L%0d", lat(k)), d[k], 32'd0);
        end
        idle(6);
        fetch(BASE);
        idle(5);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 1)), rand_addr(),
                 1'($urandom_range(0, 3) == 0), rand_addr(), $urandom,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 199) == 0));
        end
        idle(6);

        // Counter saturation.
        for (int n = 0; n < 70000; n++) fetch(BASE + 32'(n % DEPTH) * 32'd4);
        chk("req_cnt_sat", {16'd0, rc[2]}, 32'h0000_FFFF);
        for (int n = 0; n < 3; n++) fetch(BASE + 32'h3);
        chk("req_cnt_sat_hold", {16'd0, rc[0]}, 32'h0000_FFFF);

        idle(8);
        for (int k = 0; k < 3; k++) chk($sformatf("drain_L%0d", lat(k)), 32'(q[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
